// File: rtl/suffix_padder_if.sv
// ---------------------------------------------------------------------------
// suffix_padder_if
//   Bundles the absorb-path signals of suffix_padder_unit.
//   Inputs to the padder (driven by the master):
//     valid_i, state_array_i [x][y][bit], rate_i, bytes_absorbed_i, suffix_i
//   Outputs of the padder (driven by the slave):
//     state_array_o [x][y][bit], valid_o, err_o
// ---------------------------------------------------------------------------
interface suffix_padder_if #(
    parameter int ROW_SIZE          = 5,
    parameter int COL_SIZE          = 5,
    parameter int LANE_SIZE         = 64,
    parameter int RATE_WIDTH        = 11,
    parameter int BYTE_ABSORB_WIDTH = 8,
    parameter int SUFFIX_WIDTH      = 8
);
    logic                                                  valid_i;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]      state_array_i;
    logic [RATE_WIDTH-1:0]                                 rate_i;
    logic [BYTE_ABSORB_WIDTH-1:0]                          bytes_absorbed_i;
    logic [SUFFIX_WIDTH-1:0]                               suffix_i;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]      state_array_o;
    logic                                                  valid_o;
    logic                                                  err_o;

    modport master (
        output valid_i, state_array_i, rate_i, bytes_absorbed_i, suffix_i,
        input  state_array_o, valid_o, err_o
    );

    modport slave (
        input  valid_i, state_array_i, rate_i, bytes_absorbed_i, suffix_i,
        output state_array_o, valid_o, err_o
    );
endinterface

// File: rtl/suffix_padder_unit.sv
// ---------------------------------------------------------------------------
// suffix_padder_unit
//   Keccak pad10*1 with domain-separation suffix. XORs suffix_i into byte
//   bytes_absorbed_i and 0x80 into byte rate_i/8-1 of the 5x5x64 state, then
//   registers the result (1-cycle latency, one block per cycle).
//   Byte B lives in lane L=B/8 at x=L%5, y=L/5, bits [8(B%8)+7 : 8(B%8)].
//
//   Ports:
//     clk  - clock, all state changes on rising edge
//     rst  - synchronous active-high reset (dominates valid_i)
//     bus  - suffix_padder_if.slave (valid_i/state/rate/bytes/suffix in,
//            state_array_o/valid_o/err_o out)
//
//   Build option: define SUFFIX_PADDER_ERR_CHECK_EN to enable the legality
//   check (illegal rate or byte count -> pass-through and err_o=1). Without
//   it err_o is tied to 0 and padding always applies; indices >= 200 simply
//   match no byte.
// ---------------------------------------------------------------------------
module suffix_padder_unit #(
    parameter int ROW_SIZE          = 5,
    parameter int COL_SIZE          = 5,
    parameter int LANE_SIZE         = 64,
    parameter int RATE_WIDTH        = 11,
    parameter int BYTE_ABSORB_WIDTH = 8,
    parameter int SUFFIX_WIDTH      = 8
) (
    input  logic           clk,
    input  logic           rst,
    suffix_padder_if.slave bus
);
    localparam int NUM_LANES      = ROW_SIZE * COL_SIZE;
    localparam int BYTES_PER_LANE = LANE_SIZE / 8;
    localparam int IDX_W          = 16;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [7:0]       suffix_byte;
    state_t           pad_mask;
    state_t           padded_next;
    logic             illegal;
    logic             pad_en;

    state_t           state_reg;
    logic             valid_reg;

    assign head_idx    = IDX_W'(bus.bytes_absorbed_i);
    // rate 0 wraps to 0xFFFF here, which matches no byte
    assign tail_idx    = IDX_W'(bus.rate_i >> 3) - IDX_W'(1);
    assign suffix_byte = 8'(bus.suffix_i);

`ifdef SUFFIX_PADDER_ERR_CHECK_EN
    logic err_reg;

    assign illegal = (bus.rate_i == '0)
                  || (bus.rate_i[5:0] != 6'd0)
                  || (bus.rate_i > RATE_WIDTH'(1600))
                  || (head_idx >= IDX_W'(bus.rate_i >> 3));
    assign pad_en  = ~illegal;
`else
    // Low rate bits only matter to the legality check.
    logic unused_rate_bits;
    assign unused_rate_bits = &{1'b0, bus.rate_i[2:0]};
    assign illegal = 1'b0;
    assign pad_en  = 1'b1;
`endif

    // Per-byte pad mask: each byte compares its own constant index against
    // the head and tail indices, so the merged case needs no special path.
    genvar gi, gb;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam int GX = gi % ROW_SIZE;
            localparam int GY = gi / ROW_SIZE;
            for (gb = 0; gb < BYTES_PER_LANE; gb++) begin : g_byte
                localparam int BIDX = gi * BYTES_PER_LANE + gb;
                logic head_hit;
                logic tail_hit;
                assign head_hit = (head_idx == IDX_W'(BIDX));
                assign tail_hit = (tail_idx == IDX_W'(BIDX));
                assign pad_mask[GX][GY][8*gb +: 8] =
                    (head_hit ? suffix_byte : 8'h00) ^ (tail_hit ? 8'h80 : 8'h00);
            end
        end
    endgenerate

    assign padded_next = pad_en ? (bus.state_array_i ^ pad_mask) : bus.state_array_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= bus.valid_i;
            if (bus.valid_i) begin
                state_reg <= padded_next;
            end
        end
    end

`ifdef SUFFIX_PADDER_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (bus.valid_i) begin
            err_reg <= illegal;
        end
    end
    assign bus.err_o = err_reg;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.state_array_o = state_reg;
    assign bus.valid_o       = valid_reg;
endmodule

// File: tb/tb_suffix_padder_unit.sv
// ---------------------------------------------------------------------------
// tb_suffix_padder_unit
//   Directed vectors with hand-computed padded states. Inputs change away
//   from the rising edge, outputs are sampled 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_suffix_padder_unit;
    typedef logic [4:0][4:0][63:0] state_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    suffix_padder_if bus ();

    suffix_padder_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input state_t s, input int rate,
                          input int nbytes, input logic [7:0] sfx);
        bus.valid_i          = v;
        bus.state_array_i    = s;
        bus.rate_i           = 11'(rate);
        bus.bytes_absorbed_i = 8'(nbytes);
        bus.suffix_i         = sfx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                tests++;
                assert (bus.state_array_o[x][y] === exp[x][y]) else begin
                    fails++;
                    $error("FAIL %s lane[%0d][%0d] observed %h expected %h",
                           tag, x, y, bus.state_array_o[x][y], exp[x][y]);
                end
            end
        end
        $display("[TB] %s checked valid_o=%b err_o=%b", tag, bus.valid_o, bus.err_o);
    endtask

    state_t zero_s, ones_s, exp_s, held_s;

    initial begin
        tests  = 0;
        fails  = 0;
        zero_s = '0;
        ones_s = '1;

        // Reset
        rst = 1'b1;
        set_in(1'b0, zero_s, 0, 0, 8'h00);
        tick();
        tick();
        chk_bit("reset valid_o", bus.valid_o, 1'b0);
        chk_bit("reset err_o", bus.err_o, 1'b0);
        chk_state("reset", zero_s);

        @(negedge clk);
        rst = 1'b0;

        // SHA3-256 split: head byte 8 -> [1][0] bits 7:0, tail byte 135 -> [1][3] bits 63:56
        set_in(1'b1, zero_s, 1088, 8, 8'h06);
        tick();
        exp_s = '0;
        exp_s[1][0] = 64'h0000000000000006;
        exp_s[1][3] = 64'h8000000000000000;
        chk_bit("split valid_o", bus.valid_o, 1'b1);
        chk_bit("split err_o", bus.err_o, 1'b0);
        chk_state("sha3_256_split", exp_s);

        // SHA3-256 merged: head and tail both byte 135
        @(negedge clk);
        set_in(1'b1, zero_s, 1088, 135, 8'h06);
        tick();
        exp_s = '0;
        exp_s[1][3] = 64'h8600000000000000;
        chk_bit("merged valid_o", bus.valid_o, 1'b1);
        chk_state("sha3_256_merged", exp_s);

        // SHAKE128: tail byte 167 -> lane 20 -> [0][4]
        @(negedge clk);
        set_in(1'b1, zero_s, 1344, 0, 8'h1F);
        tick();
        exp_s = '0;
        exp_s[0][0] = 64'h000000000000001F;
        exp_s[0][4] = 64'h8000000000000000;
        chk_state("shake128_spill", exp_s);

        // XOR preservation on all-ones state
        @(negedge clk);
        set_in(1'b1, ones_s, 1088, 0, 8'h06);
        tick();
        exp_s = '1;
        exp_s[0][0] = 64'hFFFFFFFFFFFFFFF9;
        exp_s[1][3] = 64'h7FFFFFFFFFFFFFFF;
        chk_state("xor_preserve", exp_s);

        // Over-range byte count (136 with rate 1088)
        @(negedge clk);
        set_in(1'b1, ones_s, 1088, 136, 8'h06);
        tick();
`ifdef SUFFIX_PADDER_ERR_CHECK_EN
        chk_bit("illegal err_o", bus.err_o, 1'b1);
        chk_state("illegal_passthrough", ones_s);
        @(negedge clk);
        set_in(1'b1, zero_s, 1088, 135, 8'h06);
        tick();
        exp_s = '0;
        exp_s[1][3] = 64'h8600000000000000;
        chk_bit("legal clears err_o", bus.err_o, 1'b0);
        chk_state("legal_after_illegal", exp_s);
`else
        // Unchecked build pads anyway: head byte 136 -> lane 17 -> [2][3]
        exp_s = '1;
        exp_s[2][3] = 64'hFFFFFFFFFFFFFFF9;
        exp_s[1][3] = 64'h7FFFFFFFFFFFFFFF;
        chk_bit("unchecked err_o", bus.err_o, 1'b0);
        chk_state("unchecked_pad", exp_s);
`endif

        // Full-width rate 1600: tail byte 199 -> lane 24 -> [4][4]
        @(negedge clk);
        set_in(1'b1, zero_s, 1600, 199, 8'h1F);
        tick();
        exp_s = '0;
        exp_s[4][4] = 64'h9F00000000000000;
        chk_state("rate1600_merged", exp_s);

        // Back-to-back blocks
        @(negedge clk);
        set_in(1'b1, zero_s, 1088, 8, 8'h06);
        tick();
        exp_s = '0;
        exp_s[1][0] = 64'h0000000000000006;
        exp_s[1][3] = 64'h8000000000000000;
        chk_bit("b2b first valid_o", bus.valid_o, 1'b1);
        chk_state("b2b_first", exp_s);
        set_in(1'b1, zero_s, 1344, 0, 8'h1F);
        tick();
        exp_s = '0;
        exp_s[0][0] = 64'h000000000000001F;
        exp_s[0][4] = 64'h8000000000000000;
        chk_bit("b2b second valid_o", bus.valid_o, 1'b1);
        chk_state("b2b_second", exp_s);
        held_s = exp_s;

        // Hold: valid_i low, inputs change
        @(negedge clk);
        set_in(1'b0, ones_s, 1088, 135, 8'h06);
        tick();
        chk_bit("hold valid_o", bus.valid_o, 1'b0);
        chk_bit("hold err_o", bus.err_o, 1'b0);
        chk_state("hold", held_s);

        // Reset dominates valid_i
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b1, ones_s, 1088, 0, 8'h06);
        tick();
        chk_bit("rst+valid valid_o", bus.valid_o, 1'b0);
        chk_bit("rst+valid err_o", bus.err_o, 1'b0);
        chk_state("reset_with_valid", zero_s);

        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, ones_s, 1088, 0, 8'h06);
        tick();
        tick();
        chk_bit("post-reset valid_o", bus.valid_o, 1'b0);
        chk_bit("post-reset err_o", bus.err_o, 1'b0);
        chk_state("post_reset_idle", zero_s);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/suffix_padder_unit.md
# suffix_padder_unit

Applies Keccak pad10*1 with domain-separation suffix to the 5×5×64 state in the absorb path of the Keccak engine. XORs the suffix byte at the first unused message byte and 0x80 at the last rate byte, then registers the padded state for the permutation stage. It supports every SHA3/SHAKE rate, including the case where the suffix and the final bit land in the same byte.

## Interface
Parameters (defaults equal the keccak_pkg constants):
- ROW_SIZE, 5, x dimension of the state
- COL_SIZE, 5, y dimension of the state
- LANE_SIZE, 64, bits per lane
- RATE_WIDTH, 11, width of rate_i (holds up to 1600)
- BYTE_ABSORB_WIDTH, 8, width of bytes_absorbed_i
- SUFFIX_WIDTH, 8, width of suffix_i

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  input fields valid this cycle
- state_array_i  in  [ROW_SIZE][COL_SIZE][LANE_SIZE]  state, indexed [x][y]
- rate_i  in  RATE_WIDTH  rate in bits (1088 = SHA3-256, 1344 = SHAKE128)
- bytes_absorbed_i  in  BYTE_ABSORB_WIDTH  count of message bytes in the current block; this is the byte index of the suffix
- suffix_i  in  SUFFIX_WIDTH  suffix byte including its first pad bit (0x06 SHA3, 0x1F SHAKE)
- state_array_o  out  [ROW_SIZE][COL_SIZE][LANE_SIZE]  registered padded state
- valid_o  out  1  state_array_o updated last edge
- err_o  out  1  registered illegal-parameter flag

## Operation
- Byte mapping:
  - Byte index B maps to lane L = B/8, at x = L mod 5, y = L/5.
  - Within that lane it occupies bits [8(B mod 8)+7 : 8(B mod 8)] (little-endian).
- Head: XOR suffix_i into byte bytes_absorbed_i.
- Tail: XOR 0x80 into byte rate_i/8 − 1.
- Merged case: when head and tail are the same byte, both XORs apply. Example: 0x06 ^ 0x80 = 0x86.
- All other bits pass through unchanged. Padding is XOR, never overwrite.
- Legal inputs:
  - rate_i is a nonzero multiple of 64 and at most 1600.
  - bytes_absorbed_i < rate_i/8.
- Illegal inputs (checking compiled in): no padding is applied, state_array_i passes through unchanged, and err_o = 1.

## Timing
- Latency: 1 cycle. Outputs register on the rising edge where valid_i = 1.
- valid_o = 1 for exactly the cycle after each accepted input. Throughput is one block per cycle; back-to-back valid_i is supported.
- When valid_i = 0: state_array_o and err_o hold their values and valid_o = 0.
- Reset: while rst = 1 at an edge, state_array_o = 0, valid_o = 0, err_o = 0. Reset dominates valid_i, so an in-flight block is dropped.
- No backpressure. The consumer must take data while valid_o = 1.

## Configuration
- SUFFIX_PADDER_ERR_CHECK_EN defined: legality check active and err_o driven as in Operation.
- SUFFIX_PADDER_ERR_CHECK_EN undefined:
  - err_o is constant 0.
  - Padding is applied unconditionally.
  - A head or tail byte index at or above 200 is silently dropped.

## Test plan
- SHA3-256 split: state 0, rate 1088, bytes 8, suffix 0x06, valid pulse → next cycle valid_o = 1; lane [1][0] = 0x0000000000000006; lane [1][3] = 0x8000000000000000; all others 0.
- SHA3-256 merged: state 0, rate 1088, bytes 135, suffix 0x06 → lane [1][3] = 0x8600000000000000; all others 0.
- SHAKE128 spill: state 0, rate 1344, bytes 0, suffix 0x1F → lane [0][0] = 0x000000000000001F; lane [0][4] = 0x8000000000000000.
- XOR preservation: all lanes 0xFFFFFFFFFFFFFFFF, rate 1088, bytes 0, suffix 0x06 → lane [0][0] = 0xFFFFFFFFFFFFFFF9; lane [1][3] = 0x7FFFFFFFFFFFFFFF; all others all-ones.
- Illegal input (checking enabled): rate 1088, bytes 136 → err_o = 1 and state passed through unchanged. A following legal block clears err_o.
- Reset and hold:
  - Assert rst with valid_i = 1 → all outputs 0 next cycle.
  - Deassert rst, hold valid_i = 0 → outputs stay 0 and valid_o stays 0.
